// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - memory and register-file bus between sequencer and datapath
interface instruction_sequencer_if;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] data_SR1;
    logic        br_taken;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic [2:0]  DR;
    logic        RegWrite;
    logic        wb_sel;
    logic [1:0]  alu_op;
    logic        imm_sel;
    logic [15:0] incremented_PC;

    modport master (
        input  mem_rdata, mem_ready, data_SR1, br_taken,
        output mem_addr, mem_read, mem_write, mem_wdata,
               SR1, SR2, DR, RegWrite, wb_sel, alu_op, imm_sel, incremented_PC
    );

    modport slave (
        output mem_rdata, mem_ready, data_SR1, br_taken,
        input  mem_addr, mem_read, mem_write, mem_wdata,
               SR1, SR2, DR, RegWrite, wb_sel, alu_op, imm_sel, incremented_PC
    );
endinterface

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - multi-cycle fetch/decode/execute/mem control sequencer
module instruction_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic                          clk,
    input  logic                          rst,
    instruction_sequencer_if.master       bus,
    output logic [15:0]                   pc,
    output logic [15:0]                   ir,
    output logic                          halted
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    state_t      state, state_n;
    logic [3:0]  opcode;
    logic [15:0] off9;
    logic [15:0] off11;

    assign opcode = ir[15:12];
    assign off9   = {{7{ir[8]}}, ir[8:0]};
    assign off11  = {{5{ir[10]}}, ir[10:0]};
    assign halted = (state == HALT);

    always_comb begin
        state_n            = state;
        bus.mem_addr       = pc;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_wdata      = bus.data_SR1;
        bus.SR1            = ir[8:6];
        bus.SR2            = ir[2:0];
        bus.DR             = ir[11:9];
        bus.RegWrite       = 1'b0;
        bus.wb_sel         = 1'b0;
        bus.alu_op         = 2'b11;
        bus.imm_sel        = ir[5];
        bus.incremented_PC = pc;

        case (state)
            FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_n = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_TRAP: state_n = HALT;
                    4'b1000, 4'b1010, 4'b1011, 4'b1101,
                    4'b1110, 4'b0110, 4'b0111: state_n = FETCH;
                    default: state_n = EXECUTE;
                endcase
            end
            EXECUTE: begin
                state_n = FETCH;
                case (opcode)
                    OP_ADD: begin
                        bus.RegWrite = 1'b1;
                        bus.alu_op   = 2'b00;
                    end
                    OP_AND: begin
                        bus.RegWrite = 1'b1;
                        bus.alu_op   = 2'b01;
                    end
                    OP_NOT: begin
                        bus.RegWrite = 1'b1;
                        bus.alu_op   = 2'b10;
                    end
                    OP_JSR: begin
                        // R7 captures the pre-jump pc via incremented_PC this cycle
                        bus.RegWrite = 1'b1;
                        bus.DR       = 3'b111;
                    end
                    OP_LD, OP_ST: begin
                        bus.mem_addr = pc + off9;
                        state_n      = MEM;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                bus.mem_addr = pc + off9;
                if (opcode == OP_ST) begin
                    bus.SR1       = ir[11:9];
                    bus.mem_write = 1'b1;
                end else begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.RegWrite = 1'b1;
                        bus.wb_sel   = 1'b1;
                    end
                end
                if (bus.mem_ready) state_n = FETCH;
            end
            HALT: state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_n;
            case (state)
                FETCH: begin
                    if (bus.mem_ready) begin
                        ir <= bus.mem_rdata;
                        pc <= pc + 16'd1;
                    end
                end
                EXECUTE: begin
                    case (opcode)
                        OP_BR:   if (bus.br_taken) pc <= pc + off9;
                        OP_JMP:  pc <= bus.data_SR1;
                        OP_JSR:  pc <= pc + off11;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed table-driven bench for instruction_sequencer
module tb_instruction_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        halted;

    instruction_sequencer_if bus();

    instruction_sequencer #(.RESET_PC(16'h3000)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .pc     (pc),
        .ir     (ir),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic        br;
        logic [15:0] sr1v;
        int          delay;
        int          cycles;
        logic [15:0] exp_pc;
        int          exp_rw;
        logic [2:0]  exp_dr;
        logic        exp_wb;
        logic        chk_alu;
        logic [1:0]  exp_alu;
        logic        exp_imm;
        int          exp_rd;
        int          exp_wr;
        logic [15:0] exp_addr;
        logic [2:0]  exp_sr1;
    } vec_t;

    vec_t vecs[10];
    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int rd, wr, rw;
        logic [2:0]  dr_s, sr1_s;
        logic        wb_s, imm_s;
        logic [1:0]  alu_s;
        logic [15:0] inc_s, addr_s, wdata_s;
        rd = 0; wr = 0; rw = 0;
        dr_s = '0; sr1_s = '0; wb_s = 1'b0; imm_s = 1'b0; alu_s = '0;
        inc_s = '0; addr_s = '0; wdata_s = '0;
        do_reset();
        bus.br_taken  = v.br;
        bus.data_SR1  = v.sr1v;
        bus.mem_rdata = v.instr;
        bus.mem_ready = 1'b1;
        tick();
        for (int k = 0; k < v.cycles; k++) begin
            bus.mem_ready = 1'b0;
            #1;
            if (bus.mem_read || bus.mem_write) begin
                if (bus.mem_read) rd++;
                if (bus.mem_write) begin
                    wr++;
                    wdata_s = bus.mem_wdata;
                    sr1_s   = bus.SR1;
                end
                addr_s = bus.mem_addr;
                if (rd + wr == v.delay) bus.mem_ready = 1'b1;
                #1;
            end
            if (bus.RegWrite) begin
                rw++;
                dr_s  = bus.DR;
                wb_s  = bus.wb_sel;
                alu_s = bus.alu_op;
                imm_s = bus.imm_sel;
                inc_s = bus.incremented_PC;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        #1;
        chk({v.name, "_pc"}, pc, v.exp_pc);
        chk({v.name, "_refetch"}, {bus.mem_read, bus.mem_write, bus.mem_addr}, {1'b1, 1'b0, v.exp_pc});
        chk({v.name, "_regwrite_cycles"}, rw, v.exp_rw);
        chk({v.name, "_read_cycles"}, rd, v.exp_rd);
        chk({v.name, "_write_cycles"}, wr, v.exp_wr);
        if (v.exp_rw != 0) begin
            chk({v.name, "_dr"}, dr_s, v.exp_dr);
            chk({v.name, "_wb_sel"}, wb_s, v.exp_wb);
            chk({v.name, "_incremented_pc"}, inc_s, 16'h3001);
        end
        if (v.chk_alu) begin
            chk({v.name, "_alu_op"}, alu_s, v.exp_alu);
            chk({v.name, "_imm_sel"}, imm_s, v.exp_imm);
        end
        if (v.exp_rd + v.exp_wr != 0)
            chk({v.name, "_mem_addr"}, addr_s, v.exp_addr);
        if (v.exp_wr != 0) begin
            chk({v.name, "_wdata"}, wdata_s, v.sr1v);
            chk({v.name, "_st_sr1"}, sr1_s, v.exp_sr1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst           = 1'b1;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        bus.data_SR1  = '0;
        bus.br_taken  = 1'b0;

        //           name     instr     br    sr1v      dly cyc exp_pc    rw dr    wb    alu?  alu    imm   rd wr addr      sr1
        vecs[0] = '{"add",   16'h1261, 1'b0, 16'h0000, 1, 2, 16'h3001, 1, 3'd1, 1'b0, 1'b1, 2'b00, 1'b1, 0, 0, 16'h0000, 3'd0};
        vecs[1] = '{"and",   16'h5A82, 1'b0, 16'h0000, 1, 2, 16'h3001, 1, 3'd5, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 16'h0000, 3'd0};
        vecs[2] = '{"not",   16'h9C7F, 1'b0, 16'h0000, 1, 2, 16'h3001, 1, 3'd6, 1'b0, 1'b1, 2'b10, 1'b1, 0, 0, 16'h0000, 3'd0};
        vecs[3] = '{"ld",    16'h2402, 1'b0, 16'h0000, 3, 5, 16'h3001, 1, 3'd2, 1'b1, 1'b0, 2'b00, 1'b0, 3, 0, 16'h3003, 3'd0};
        vecs[4] = '{"br_t",  16'h0FFE, 1'b1, 16'h0000, 1, 2, 16'h2FFF, 0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 16'h0000, 3'd0};
        vecs[5] = '{"br_n",  16'h0FFE, 1'b0, 16'h0000, 1, 2, 16'h3001, 0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 16'h0000, 3'd0};
        vecs[6] = '{"jsr",   16'h4805, 1'b0, 16'h0000, 1, 2, 16'h3006, 1, 3'd7, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 16'h0000, 3'd0};
        vecs[7] = '{"jmp",   16'hC080, 1'b0, 16'h1234, 1, 2, 16'h1234, 0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 16'h0000, 3'd0};
        vecs[8] = '{"st",    16'h3604, 1'b0, 16'hBEEF, 2, 4, 16'h3001, 0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 2, 16'h3005, 3'd3};
        vecs[9] = '{"nop",   16'hB000, 1'b0, 16'h0000, 1, 1, 16'h3001, 0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 16'h0000, 3'd0};

        // Reset state
        do_reset();
        #1;
        chk("reset_pc", pc, 16'h3000);
        chk("reset_ir", ir, 16'h0000);
        chk("reset_halted", halted, 1'b0);
        chk("reset_strobes", {bus.mem_read, bus.mem_write, bus.RegWrite}, 3'b100);
        chk("reset_mem_addr", bus.mem_addr, 16'h3000);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // TRAP halts and ignores later mem_ready pulses until reset
        do_reset();
        bus.mem_rdata = 16'hF025;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        #1;
        chk("trap_halted", halted, 1'b1);
        chk("trap_strobes", {bus.mem_read, bus.mem_write, bus.RegWrite}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            bus.mem_ready = 1'b1;
            tick();
        end
        bus.mem_ready = 1'b0;
        #1;
        chk("trap_pc_frozen", pc, 16'h3001);
        chk("trap_ir_frozen", ir, 16'hF025);
        chk("trap_still_halted", halted, 1'b1);
        do_reset();
        #1;
        chk("trap_rst_pc", pc, 16'h3000);
        chk("trap_rst_halted", halted, 1'b0);

        // Reset in the middle of a store wait
        do_reset();
        bus.mem_rdata = 16'h3604;
        bus.data_SR1  = 16'h5555;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("st_wait_write", bus.mem_write, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("st_rst_write_drop", bus.mem_write, 1'b0);
        chk("st_rst_fetch", {bus.mem_read, bus.mem_addr}, {1'b1, 16'h3000});

        // PC wraps from FFFF to 0000 on fetch
        do_reset();
        bus.mem_rdata = 16'hC080;
        bus.data_SR1  = 16'hFFFF;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("wrap_fetch_addr", bus.mem_addr, 16'hFFFF);
        bus.mem_rdata = 16'hB000;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("wrap_pc", pc, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h3000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mem_rdata  input  16  memory read data (instruction or load data).
REQ-005 SHALL have port mem_ready  input  1  memory completes the current read/write this cycle.
REQ-006 SHALL have port data_SR1  input  16  register-file read data for SR1.
REQ-007 SHALL have port br_taken  input  1  register-file branch condition for the nzp bits presented on DR.
REQ-008 SHALL have port mem_addr  output  16  memory address.
REQ-009 SHALL have port mem_read / mem_write  output  1 each  memory request strobes, mutually exclusive.
REQ-010 SHALL have port mem_wdata  output  16  store data, equal to data_SR1.
REQ-011 SHALL have port SR1, SR2, DR  output  3 each  register-file select fields.
REQ-012 SHALL have port RegWrite  output  1  register-file write enable.
REQ-013 SHALL have port wb_sel  output  1  0 = ALU result, 1 = mem_rdata as register write data.
REQ-014 SHALL have port alu_op  output  2  00 ADD, 01 AND, 10 NOT, 11 pass.
REQ-015 SHALL have port imm_sel  output  1  IR[5]; ALU operand B from sext(IR[4:0]).
REQ-016 SHALL have port incremented_PC  output  16  current PC (already PC+1 after fetch), feeds R7 on link.
REQ-017 SHALL have port pc, ir  output  16 each  architectural PC and instruction register.
REQ-018 SHALL have port halted  output  1  sequencer stopped on TRAP.

Function
REQ-019 SHALL implement the states FETCH, DECODE, EXECUTE, MEM and HALT.
REQ-020 FETCH SHALL hold mem_read=1 and mem_addr=pc until mem_ready; on mem_ready, ir<=mem_rdata, pc<=pc+1 (mod 2^16), next state DECODE.
REQ-021 DECODE SHALL last exactly 1 cycle; from DECODE, opcode 1111 -> HALT, opcodes 1000/1010/1011/1101/1110/0110/0111 -> FETCH (NOP), all others -> EXECUTE.
REQ-022 SR1=ir[8:6], SR2=ir[2:0] and DR=ir[11:9] SHALL be driven in every state except that ST in MEM drives SR1=ir[11:9] and JSR in EXECUTE drives DR=3'b111.
REQ-023 ADD(0001)/AND(0101)/NOT(1001) SHALL assert RegWrite=1, wb_sel=0 and the matching alu_op for exactly the 1 EXECUTE cycle, then go to FETCH.
REQ-024 BR(0000) SHALL, in EXECUTE, set pc<=pc+sext(ir[8:0]) if br_taken=1 and otherwise leave pc unchanged; RegWrite SHALL stay 0; next state FETCH.
REQ-025 JMP(1100) SHALL set pc<=data_SR1 in EXECUTE; next state FETCH.
REQ-026 JSR(0100) SHALL assert RegWrite=1 with DR=7 and set pc<=pc+sext(ir[10:0]) in the same cycle; R7 receives the pre-update pc through incremented_PC; next state FETCH.
REQ-027 LD(0010)/ST(0011) SHALL go from EXECUTE to MEM with mem_addr=pc+sext(ir[8:0]); memory strobes SHALL be 0 in EXECUTE.
REQ-028 In MEM, LD SHALL hold mem_read=1 until mem_ready; in the mem_ready cycle it SHALL assert RegWrite=1 with wb_sel=1, then go to FETCH.
REQ-029 In MEM, ST SHALL hold mem_write=1 with mem_wdata=data_SR1 until mem_ready, with RegWrite=0, then go to FETCH.
REQ-030 RegWrite SHALL never be asserted outside EXECUTE/MEM or for more than 1 cycle per instruction.
REQ-031 All address arithmetic SHALL be 16-bit and wrap modulo 2^16 (pc=16'hFFFF fetch -> pc=16'h0000).
REQ-032 HALT SHALL be absorbing: halted=1, all strobes 0, pc and ir frozen until rst.
REQ-033 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-034 rst=1 at a posedge SHALL force state=FETCH, pc=RESET_PC, ir=0 and halted=0 regardless of the current state, including mid-wait in FETCH/MEM.
REQ-035 After reset, combinational outputs SHALL read RegWrite=0, mem_write=0 and mem_read=1 (FETCH), with mem_addr=RESET_PC.

Verification
REQ-036 The bench SHALL cover: reset, then instruction 16'h1261 (ADD R1,R1,#1) with mem_ready=1 -> FETCH, DECODE, EXECUTE; RegWrite=1 for 1 cycle with DR=1 and imm_sel=1; pc=3001.
REQ-037 The bench SHALL cover: LD 16'h2402 at pc 3000 with mem_ready delayed 3 cycles in MEM -> mem_addr=3003 and mem_read held 3 cycles; RegWrite=1 and wb_sel=1 only in the mem_ready cycle.
REQ-038 The bench SHALL cover: BR 16'h0FFE with br_taken=1 -> pc=2FFF; with br_taken=0 -> pc=3001; RegWrite=0 in both cases.
REQ-039 The bench SHALL cover: JSR 16'h4805 at 3000 -> DR=7, RegWrite=1, incremented_PC=3001, then pc=3006.
REQ-040 The bench SHALL cover: TRAP 16'hF025 -> halted=1; further mem_ready pulses leave pc unchanged; rst -> pc=3000, halted=0.
REQ-041 The bench SHALL cover: rst asserted during a ST MEM wait -> mem_write drops the next cycle and the state is FETCH.
